// File: rtl/db_stream_ctrl_if.sv
// db_stream_ctrl_if: DDR word-read request channel with in-order data returns.
interface db_stream_ctrl_if;
  logic         ddrReq;
  logic [31:0]  ddrAddr;
  logic         ddrAck;
  logic [511:0] ddrData;
  logic         ddrDataValid;
  modport master (output ddrReq, ddrAddr, input ddrAck, ddrData, ddrDataValid);
  modport slave  (input ddrReq, ddrAddr, output ddrAck, ddrData, ddrDataValid);
endinterface

// File: rtl/db_stream_ctrl.sv
// db_stream_ctrl: prefetches database words from DDR, feeds the Hit engine and reports hits.
// Defining HIT_COUNT_EN adds a saturating 16-bit hitCount output.
module db_stream_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      dbLength,
  db_stream_ctrl_if.master ddr,
  output logic [511:0]     dataBase,
  output logic             dataBaseValid,
  output logic             load,
  output logic             shift,
  input  logic [8:0]       ShiftNo,
  input  logic             hit,
  input  logic [8:0]       locationQ,
  output logic             hitValid,
  output logic [8:0]       hitQLoc,
  output logic [40:0]      hitDbOffset,
  output logic             busy,
  output logic             done
`ifdef HIT_COUNT_EN
  ,output logic [15:0]     hitCount
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, REPORT, FINISH} state_t;
  state_t       state;
  logic [31:0]  len, word_idx, req_idx;
  logic [511:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt, fill;
  logic         req_fire, wr_en, pop;
  // cnt reserves a slot per issued request; fill counts words actually returned
  assign busy         = state != IDLE;
  assign ddr.ddrReq   = busy && cnt < 2'd2 && req_idx < len;
  assign ddr.ddrAddr  = req_idx;
  assign req_fire     = ddr.ddrReq && ddr.ddrAck;
  assign wr_en        = ddr.ddrDataValid && busy;
  assign pop          = state == LOAD && fill != 2'd0;
  assign shift        = state == SCAN && !hit;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= ddr.ddrData;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      len           <= '0;
      word_idx      <= '0;
      req_idx       <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      cnt           <= '0;
      fill          <= '0;
      dataBase      <= '0;
      dataBaseValid <= 1'b0;
      load          <= 1'b0;
      hitValid      <= 1'b0;
      hitQLoc       <= '0;
      hitDbOffset   <= '0;
      done          <= 1'b0;
    end else begin
      load     <= 1'b0;
      hitValid <= 1'b0;
      done     <= 1'b0;
      req_idx  <= req_idx + 32'(req_fire);
      wr_ptr   <= wr_ptr ^ wr_en;
      rd_ptr   <= rd_ptr ^ pop;
      cnt      <= cnt + 2'(req_fire) - 2'(pop);
      fill     <= fill + 2'(wr_en) - 2'(pop);
      case (state)
        IDLE: if (start) begin
          len      <= dbLength;
          word_idx <= '0;
          req_idx  <= '0;
          wr_ptr   <= 1'b0;
          rd_ptr   <= 1'b0;
          cnt      <= '0;
          fill     <= '0;
          state    <= dbLength == 32'd0 ? FINISH : LOAD;
        end
        LOAD: if (pop) begin
          dataBase      <= mem[rd_ptr];
          load          <= 1'b1;
          dataBaseValid <= 1'b1;
          state         <= SCAN;
        end
        // a hit suppresses shift, so a coincident wrap is taken after REPORT
        SCAN: if (hit) begin
          hitValid    <= 1'b1;
          hitQLoc     <= locationQ;
          hitDbOffset <= {word_idx, ShiftNo};
          state       <= REPORT;
        end else if (ShiftNo == 9'd511) begin
          word_idx <= word_idx + 32'd1;
          state    <= {1'b0, word_idx} + 33'd1 < {1'b0, len} ? LOAD : FINISH;
        end
        REPORT: state <= SCAN;
        FINISH: begin
          done          <= 1'b1;
          dataBaseValid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef HIT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hitCount <= '0;
    else if (state == IDLE && start) hitCount <= '0;
    else if (hitValid && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_db_stream_ctrl.sv
// tb_db_stream_ctrl: random-latency DDR and Hit-engine models with a scoreboard around db_stream_ctrl.
module tb_db_stream_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, hit = 1'b0;
  logic [31:0] dbLength = '0;
  logic [8:0] ShiftNo = '0, locationQ = '0;
  logic [511:0] dataBase;
  logic dataBaseValid, load, shift, hitValid, busy, done;
  logic [8:0] hitQLoc;
  logic [40:0] hitDbOffset;
`ifdef HIT_COUNT_EN
  logic [15:0] hitCount;
`endif
  db_stream_ctrl_if ddr();
  db_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dbLength(dbLength), .ddr(ddr),
    .dataBase(dataBase), .dataBaseValid(dataBaseValid), .load(load), .shift(shift),
    .ShiftNo(ShiftNo), .hit(hit), .locationQ(locationQ), .hitValid(hitValid),
    .hitQLoc(hitQLoc), .hitDbOffset(hitDbOffset), .busy(busy), .done(done)
`ifdef HIT_COUNT_EN
    , .hitCount(hitCount)
`endif
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, ld_cnt = 0, cur_word = -1, n_shift = 0, n_hit = 0, n_fire = 0, n_done = 0, n_req = 0;
  int done_cyc = 0, start_cyc = 0, exp_addr = 0, lat_max = 3;
  bit stall = 1'b0, ack_always = 1'b0;
  logic [8:0] sn = '0;
  logic [31:0] seed = '0;
  int tw[$], tp[$], tq[$], pa[$], pd[$];

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] word_of(int a);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = 32'(a) * 32'h9E37_79B1 + 32'(i) + seed;
    return w;
  endfunction

  // DDR memory and Hit engine models: inputs change on the falling edge
  initial begin
    ddr.ddrAck = 1'b0;
    ddr.ddrDataValid = 1'b0;
    ddr.ddrData = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (load) begin
        cur_word = ld_cnt;
        ld_cnt++;
        check("load_data", dataBase, word_of(cur_word));
        check("load_valid", 512'(dataBaseValid), 512'd1);
      end
      if (hitValid) begin
        n_hit++;
        if (tw.size() == 0) check("hit_spurious", 512'(hitValid), 512'd0);
        else begin
          check("hit_qloc", 512'(hitQLoc), 512'(tq[0]));
          check("hit_offset", 512'(hitDbOffset), 512'(tw[0] * 512 + tp[0]));
          void'(tw.pop_front());
          void'(tp.pop_front());
          void'(tq.pop_front());
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (!rst) begin
        sn = '0;
        cur_word = -1;
        ld_cnt = 0;
      end
      ShiftNo = sn;
      hit = tw.size() > 0 ? (cur_word == tw[0] && int'(sn) == tp[0]) : 1'b0;
      locationQ = tw.size() > 0 ? 9'(tq[0]) : 9'd0;
      ddr.ddrDataValid = pd.size() > 0 ? pd[0] <= cyc : 1'b0;
      if (ddr.ddrDataValid) begin
        ddr.ddrData = word_of(pa[0]);
        void'(pa.pop_front());
        void'(pd.pop_front());
      end
      ddr.ddrAck = !stall && (ack_always || $urandom_range(0, 3) != 0);
      #1;
      if (ddr.ddrReq) n_req++;
      if (shift) begin
        n_shift++;
        sn++;
      end
      if (hit) check("shift_on_hit", 512'(shift), 512'd0);
      if (ddr.ddrReq && ddr.ddrAck) begin
        check("ddr_addr", 512'(ddr.ddrAddr), 512'(exp_addr));
        check("fifo_depth", 512'(n_fire - ld_cnt < 2), 512'd1);
        pa.push_back(int'(ddr.ddrAddr));
        pd.push_back(cyc + int'($urandom_range(1, lat_max)));
        exp_addr++;
        n_fire++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic add_tgt(int w, int p, int q);
    tw.push_back(w);
    tp.push_back(p);
    tq.push_back(q);
  endtask

  task automatic check_quiet(string t);
    check({t, "_busy"}, 512'(busy), 512'd0);
    check({t, "_done"}, 512'(done), 512'd0);
    check({t, "_load"}, 512'(load), 512'd0);
    check({t, "_shift"}, 512'(shift), 512'd0);
    check({t, "_hitvalid"}, 512'(hitValid), 512'd0);
    check({t, "_hitqloc"}, 512'(hitQLoc), 512'd0);
    check({t, "_hitoffset"}, 512'(hitDbOffset), 512'd0);
    check({t, "_dbvalid"}, 512'(dataBaseValid), 512'd0);
    check({t, "_database"}, dataBase, 512'd0);
    check({t, "_ddrreq"}, 512'(ddr.ddrReq), 512'd0);
    check({t, "_ddraddr"}, 512'(ddr.ddrAddr), 512'd0);
  endtask

  task automatic begin_run(int len);
    dbLength = 32'(len);
    ld_cnt = 0; cur_word = -1; n_shift = 0; n_hit = 0;
    n_fire = 0; n_done = 0; n_req = 0; exp_addr = 0;
    tick();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(int len, int nh);
    for (int i = 0; i < len * 800 + 2000 && n_done == 0; i++) tick();
    check("done_seen", 512'(n_done), 512'd1);
    check("busy_after", 512'(busy), 512'd0);
    check("loads", 512'(ld_cnt), 512'(len));
    check("shifts", 512'(n_shift), 512'(len * 512));
    check("hits", 512'(n_hit), 512'(nh));
    check("fires", 512'(n_fire), 512'(len));
    check("targets_left", 512'(tw.size()), 512'd0);
    if (len == 0) begin
      check("done_latency", 512'(done_cyc - start_cyc), 512'd2);
      check("no_req", 512'(n_req), 512'd0);
    end
`ifdef HIT_COUNT_EN
    check("hit_count", 512'(hitCount), 512'(nh));
`endif
    tick();
    check("done_pulse", 512'(done), 512'd0);
    check("dbvalid_after", 512'(dataBaseValid), 512'd0);
  endtask

  initial begin
    seed = $urandom;
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b1;
    tick();
    check_quiet("idle");
    begin_run(0);
    finish_run(0, 0);
    lat_max = 1;
    ack_always = 1'b1;
    begin_run(2);
    finish_run(2, 0);
    lat_max = 3;
    ack_always = 1'b0;
    add_tgt(0, 37, 5);
    begin_run(1);
    finish_run(1, 1);
    add_tgt(1, 511, 300);
    begin_run(3);
    finish_run(3, 1);
    // memory stall before the first word, then again while word 3 is due
    stall = 1'b1;
    begin_run(4);
    repeat (20) tick();
    check("stall0_shift", 512'(shift), 512'd0);
    check("stall0_load", 512'(load), 512'd0);
    check("stall0_dbvalid", 512'(dataBaseValid), 512'd0);
    check("stall0_busy", 512'(busy), 512'd1);
    check("stall0_req", 512'(ddr.ddrReq), 512'd1);
    repeat (30) tick();
    stall = 1'b0;
    for (int i = 0; i < 200 && n_fire < 3; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3000 && n_shift < 1536; i++) tick();
    repeat (5) tick();
    check("stall1_shift", 512'(shift), 512'd0);
    check("stall1_load", 512'(load), 512'd0);
    check("stall1_dbvalid", 512'(dataBaseValid), 512'd1);
    check("stall1_loads", 512'(ld_cnt), 512'd3);
    check("stall1_busy", 512'(busy), 512'd1);
    repeat (45) tick();
    stall = 1'b0;
    finish_run(4, 0);
    for (int r = 0; r < 3; r++) begin
      int len, nh;
      len = int'($urandom_range(1, 4));
      nh = 0;
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 1) == 1) begin
          add_tgt(w, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)));
          nh++;
        end
        if ($urandom_range(0, 1) == 1) begin
          add_tgt(w, int'($urandom_range(256, 511)), int'($urandom_range(0, 511)));
          nh++;
        end
      end
      begin_run(len);
      finish_run(len, nh);
    end
    // asynchronous reset in the middle of word 1, then a fresh scan
    begin_run(3);
    for (int i = 0; i < 3000 && !(ld_cnt == 2 && n_shift > 700); i++) tick();
    rst = 1'b0;
    #1;
    check_quiet("async_rst");
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    check_quiet("post_rst");
    begin_run(2);
    finish_run(2, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/db_stream_ctrl.md
DB_STREAM_CTRL -- requirements
Module: db_stream_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle pulse that begins a scan; ignored unless IDLE.
REQ-004 SHALL have port: dbLength  input  32  number of 512-bit database words to scan; sampled on start.
REQ-005 SHALL have ports: ddrReq  output  1 / ddrAddr  output  32 / ddrAck  input  1; word read request, which completes on a cycle with ddrReq&ddrAck.
REQ-006 SHALL have ports: ddrData  input  512 / ddrDataValid  input  1; read returns arrive in request order, and the block always accepts them.
REQ-007 SHALL have ports to Hit: dataBase  output  512, dataBaseValid  output  1, load  output  1, shift  output  1.
REQ-008 SHALL have ports from Hit: ShiftNo  input  9, hit  input  1, locationQ  input  9.
REQ-009 SHALL have ports: hitValid  output  1, hitQLoc  output  9, hitDbOffset  output  41, busy  output  1, done  output  1.

Function
REQ-010 SHALL implement the FSM states IDLE, LOAD, SCAN, REPORT and FINISH.
REQ-011 SHALL, in IDLE on start: latch dbLength, clear wordIdx/reqIdx, and go to FINISH if dbLength==0, otherwise go to LOAD; busy=1 in every state except IDLE.
REQ-012 SHALL keep a 2-entry prefetch FIFO whose entry count includes outstanding requests, and SHALL assert ddrReq whenever busy, count<2 and reqIdx<length, with ddrAddr=reqIdx.
REQ-013 SHALL increment reqIdx on each ddrReq&ddrAck, and SHALL write the FIFO on each ddrDataValid.
REQ-014 SHALL act in LOAD only when the FIFO holds data: pop to dataBase, pulse load=1 for one cycle, set dataBaseValid=1, then go to SCAN; if the FIFO is empty, LOAD SHALL wait with load=0 and shift=0.
REQ-015 SHALL drive shift=1 in SCAN on every cycle where hit==0, and shift=0 on the cycle hit==1.
REQ-016 SHALL, on hit==1 in SCAN, go to REPORT and drive hitValid=1 for exactly one cycle with hitQLoc=locationQ and hitDbOffset={wordIdx[31:0],ShiftNo} (wordIdx*512+ShiftNo); SCAN resumes on the next cycle.
REQ-017 SHALL end the word when shift==1 and ShiftNo==511 (wrap): increment wordIdx, then go to LOAD if wordIdx+1<length, else go to FINISH.
REQ-018 SHALL give hit priority when hit and the wrap condition occur in the same cycle: the hit is reported first, and the wrap is taken when scanning resumes.
REQ-019 SHALL, in FINISH, pulse done=1 for one cycle, set dataBaseValid=0 and return to IDLE; start in FINISH is ignored.
REQ-020 SHALL give ddrDataValid arriving in the same cycle as a LOAD pop both operations: the count stays unchanged and no data is lost.
REQ-021 SHALL clear all addition carries into a 41-bit result; hitDbOffset SHALL be valid only while hitValid=1.

Reset
REQ-022 SHALL, when rst=0 (at any time, including mid-scan): state=IDLE, FIFO empty, reqIdx=wordIdx=0, all outputs 0, dataBase=0.
REQ-023 SHALL discard any ddrDataValid beats for pre-reset requests that arrive after reset, while IDLE.

Configuration
REQ-024 SHALL, with HIT_COUNT_EN defined, add output hitCount (16 bits), which is cleared on start and reset, increments on each hitValid, and saturates at 0xFFFF.
REQ-025 SHALL, without HIT_COUNT_EN, have no hitCount port and no counter logic; all other behaviour is identical.

Verification
REQ-026 SHALL cover: dbLength=0, start -> done pulse two cycles later, with no ddrReq and no load.
REQ-027 SHALL cover: dbLength=2, ddr 1-cycle latency, no hits -> 2 load pulses, 1024 shift cycles, ddrAddr 0 then 1, one done.
REQ-028 SHALL cover: dbLength=1, hit forced when ShiftNo=37, locationQ=5 -> hitValid once, hitQLoc=5, hitDbOffset=37, shift=0 that cycle.
REQ-029 SHALL cover: dbLength=3, hit coincides with ShiftNo=511 on word 1 -> hitDbOffset=1023, then load of word 2, with no skipped word.
REQ-030 SHALL cover: ddrAck held low 50 cycles -> LOAD stalls with shift=0, dataBaseValid held, and it resumes correctly.
REQ-031 SHALL cover: rst low mid-SCAN of word 1 -> all outputs 0 asynchronously, IDLE, and a new start rescans from address 0.
